// File: rtl/bfu_pkg.sv
// bfu_pkg: modulus constants, mode enum and modular helpers shared by the butterfly and poly-multiply units
package bfu_pkg;
   typedef enum logic {BFU_NTT = 1'b0, BFU_INTT = 1'b1} bfu_mode_e;
   typedef logic [63:0] bfu_word_t;
   function automatic int unsigned bfu_k(input int unsigned q);
      return int'($clog2(q));
   endfunction
   function automatic longint unsigned bfu_mu(input int unsigned q, input int unsigned k);
      return (64'd1 << (2 * k)) / 64'(q);
   endfunction
   localparam int unsigned BFU_Q = 8380417;
   localparam int unsigned BFU_K = bfu_k(BFU_Q);
   localparam longint unsigned BFU_MU = bfu_mu(BFU_Q, BFU_K);
   function automatic bfu_word_t mod_add(input bfu_word_t a, input bfu_word_t b, input bfu_word_t q);
      return (a + b >= q) ? a + b - q : a + b;
   endfunction
   function automatic bfu_word_t mod_sub(input bfu_word_t a, input bfu_word_t b, input bfu_word_t q);
      return (a >= b) ? a - b : a + q - b;
   endfunction
   function automatic bfu_word_t mod_half(input bfu_word_t x, input bfu_word_t q);
      return x[0] ? (x + q) >> 1 : x >> 1;
   endfunction
endpackage

// File: rtl/mod_mul_barrett.sv
// mod_mul_barrett: 2-cycle modular multiplier (product, then Barrett reduction) with a stall enable
module mod_mul_barrett
   import bfu_pkg::*;
#(
   parameter int unsigned K = BFU_K,
   parameter int unsigned Q = BFU_Q,
   parameter longint unsigned MU = BFU_MU
) (
   input  logic         clk_i,
   input  logic         en_i,
   input  logic [K-1:0] a_i,
   input  logic [K-1:0] b_i,
   output logic [K-1:0] r_o
);
   localparam logic [K+1:0] QW = (K+2)'(Q);
   localparam logic [2*K+1:0] MW = (2*K+2)'(MU);
   logic [2*K-1:0] p_d, p_q;
   logic [2*K+1:0] qm;
   logic [K+1:0] qe, r0, r1, r2;
   logic [K-1:0] r_d, r_q;
   always_comb begin
      p_d = en_i ? (2*K)'(a_i) * (2*K)'(b_i) : p_q;
      qm = ((2*K+2)'(p_q) >> (K - 1)) * MW;
      qe = (K+2)'(qm >> (K + 1));
      // quotient estimate is short by at most 2, so the remainder stays below 3Q
      r0 = (K+2)'(p_q) - qe * QW;
      r1 = (r0 >= QW) ? r0 - QW : r0;
      r2 = (r1 >= QW) ? r1 - QW : r1;
      r_d = en_i ? K'(r2) : r_q;
   end
   always_ff @(posedge clk_i) begin
      p_q <= p_d;
      r_q <= r_d;
   end
   assign r_o = r_q;
endmodule

// File: rtl/ntt_intt_bfu.sv
// ntt_intt_bfu: 4-stage NTT (CT) / INTT (GS) modular butterfly; define BFU_INTT_HALVE_EN to halve INTT outputs
module ntt_intt_bfu
   import bfu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned Q = BFU_Q,
   parameter int unsigned K = bfu_k(Q)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  mode_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   input  logic [DATA_WIDTH-1:0] data2_i,
   input  logic [DATA_WIDTH-1:0] w_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] data1_o,
   output logic [DATA_WIDTH-1:0] data2_o,
   output logic                  mode_o
);
   localparam longint unsigned MU = bfu_mu(Q, K);
   localparam bfu_word_t QW = bfu_word_t'(Q);
   logic en, ld;
   logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, v4_d, v4_q;
   bfu_mode_e m1_d, m1_q, m2_d, m2_q, m3_d, m3_q, m4_d, m4_q;
   logic [K-1:0] a1_d, a1_q, b1_d, b1_q, w1_d, w1_q, a2_d, a2_q, a3_d, a3_q;
   logic [K-1:0] t, ha, hb, o1_d, o1_q, o2_d, o2_q;
   bfu_word_t ai, bi;
   mod_mul_barrett #(.K(K), .Q(Q), .MU(MU)) u_mul (
      .clk_i(clk_i),
      .en_i (en),
      .a_i  (b1_q),
      .b_i  (w1_q),
      .r_o  (t)
   );
   always_comb begin
      en = !v4_q || out_ready_i;
      ld = en && v3_q;
      ai = bfu_word_t'(K'(data1_i));
      bi = bfu_word_t'(K'(data2_i));
      v1_d = en ? in_valid_i : v1_q;
      m1_d = en ? bfu_mode_e'(mode_i) : m1_q;
      a1_d = en ? (mode_i ? K'(mod_add(ai, bi, QW)) : K'(data1_i)) : a1_q;
      b1_d = en ? (mode_i ? K'(mod_sub(ai, bi, QW)) : K'(data2_i)) : b1_q;
      w1_d = en ? K'(w_i) : w1_q;
      v2_d = en ? v1_q : v2_q;
      m2_d = en ? m1_q : m2_q;
      a2_d = en ? a1_q : a2_q;
      v3_d = en ? v2_q : v3_q;
      m3_d = en ? m2_q : m3_q;
      a3_d = en ? a2_q : a3_q;
`ifdef BFU_INTT_HALVE_EN
      ha = K'(mod_half(bfu_word_t'(a3_q), QW));
      hb = K'(mod_half(bfu_word_t'(t), QW));
`else
      ha = a3_q;
      hb = t;
`endif
      // output registers only load real results so they hold zero until the first one
      v4_d = en ? v3_q : v4_q;
      m4_d = ld ? m3_q : m4_q;
      o1_d = ld ? (m3_q == BFU_INTT ? ha : K'(mod_add(bfu_word_t'(a3_q), bfu_word_t'(t), QW))) : o1_q;
      o2_d = ld ? (m3_q == BFU_INTT ? hb : K'(mod_sub(bfu_word_t'(a3_q), bfu_word_t'(t), QW))) : o2_q;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         v4_q <= 1'b0;
         m1_q <= BFU_NTT;
         m2_q <= BFU_NTT;
         m3_q <= BFU_NTT;
         m4_q <= BFU_NTT;
         a1_q <= '0;
         b1_q <= '0;
         w1_q <= '0;
         a2_q <= '0;
         a3_q <= '0;
         o1_q <= '0;
         o2_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         v4_q <= v4_d;
         m1_q <= m1_d;
         m2_q <= m2_d;
         m3_q <= m3_d;
         m4_q <= m4_d;
         a1_q <= a1_d;
         b1_q <= b1_d;
         w1_q <= w1_d;
         a2_q <= a2_d;
         a3_q <= a3_d;
         o1_q <= o1_d;
         o2_q <= o2_d;
      end
   end
   assign in_ready_o = en;
   assign out_valid_o = v4_q;
   assign data1_o = DATA_WIDTH'(o1_q);
   assign data2_o = DATA_WIDTH'(o2_q);
   assign mode_o = m4_q;
endmodule

// File: doc/ntt_intt_bfu.md
# ntt_intt_bfu

Pipelined, parametrised butterfly unit performing one modular Cooley-Tukey (NTT) or Gentleman-Sande (INTT) butterfly per accepted transaction. Mode is selected per transaction. Every result is fully reduced mod Q. The block sits between the coefficient-memory read port and write-back path of the transform engine, with a valid/ready handshake on both sides.

## Interface
- DATA_WIDTH, 32: port width of coefficients and twiddle; upper bits above K are zero on output.
- Q, 8380417: prime modulus; Q < 2^(DATA_WIDTH-1), Q odd.
- K, $clog2(Q): reduction width; 23 for the default Q.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  block can accept an input this cycle.
- mode_i  in  1  0 = NTT (CT), 1 = INTT (GS); sampled with the data.
- data1_i, data2_i  in  DATA_WIDTH  operands a, b; the producer guarantees both are < Q.
- w_i  in  DATA_WIDTH  twiddle; the producer guarantees it is < Q.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- data1_o, data2_o  out  DATA_WIDTH  results a', b', each in [0, Q).
- mode_o  out  1  mode of the transaction on the output.

## Operation
- NTT: t = w·b mod Q; a' = (a + t) mod Q; b' = (a − t) mod Q.
- INTT: a' = half((a + b) mod Q); b' = half(((a − b) mod Q)·w mod Q).
- half(x) = x>>1 if x is even, else (x+Q)>>1.
- Modular add: sum minus Q if the sum is ≥ Q. Modular subtract: difference plus Q if the difference is negative. Both are computed at K+1 bits.
- Multiply: 2K-bit product, Barrett reduction with mu = floor(2^(2K)/Q), then at most two conditional subtractions of Q. The result is exact for every product of two operands < Q.
- Pipeline stages:
  - S1: register operands; for INTT compute (a+b) mod Q and (a−b) mod Q.
  - S2: product (NTT: w·b; INTT: w·diff).
  - S3: Barrett reduce.
  - S4: NTT add/sub, or INTT halving; register outputs.
- Each stage carries its own valid bit and mode bit.

## Timing
- Latency: 4 cycles from input handshake to out_valid_o, with no stalls.
- Throughput: one transaction per cycle.
- in_ready_o = !s4_valid || out_ready_i. When in_ready_o is low, the entire pipeline freezes (global stall). No bubble collapse.
- Input is accepted when in_valid_i && in_ready_o. Output completes when out_valid_o && out_ready_i.
- While out_valid_o is high and out_ready_i is low, data1_o, data2_o and mode_o hold stable.
- A simultaneous input accept and output drain in the same cycle is legal and loses nothing.
- Reset:
  - Clears all stage valids; out_valid_o = 0; data1_o = data2_o = 0; mode_o = 0.
  - in_ready_o = 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight transaction. No partial result is ever emitted.
- in_ready_o is combinational from out_ready_i. There is no combinational path from in_valid_i to any output.

## Configuration
- BFU_INTT_HALVE_EN defined: INTT applies half() to both outputs, as specified above. Default build.
- BFU_INTT_HALVE_EN undefined:
  - INTT outputs a' = (a+b) mod Q and b' = ((a−b)·w) mod Q, with no halving.
  - The final n^-1 scaling happens downstream.
  - Latency and handshake are unchanged; S4 registers the values through.
- NTT mode is unaffected by the macro.

## Structure
- Package bfu_pkg holds:
  - bfu_mode_e enum (BFU_NTT, BFU_INTT).
  - Localparam functions for K and Barrett mu derived from Q.
  - mod_add, mod_sub and mod_half functions.
- Sub-module mod_mul_barrett spans S2–S3. It is parametrised on K, Q and MU. It takes an enable (stall) input and has a fixed 2-cycle latency.
- The Q, K and mu constants are shared with the future polynomial-multiply unit.

## Test plan
- NTT round-trip, default Q, halving on:
  - NTT a=1, b=2, w=1 → a'=3, b'=8380416.
  - Feed that result as INTT with w=1 → a'=1, b'=2.
- Odd halving: INTT a=1, b=0, w=1 → a'=4190209, b'=4190209. With the macro off → a'=1, b'=1.
- Extreme operands: NTT a=b=w=8380416 → t=1, a'=0, b'=8380415.
- Streaming and backpressure:
  - 16 back-to-back transactions with alternating mode.
  - out_ready_i held low for 3 cycles mid-stream → in_ready_o low during the stall, outputs stable, all 16 results correct and in order.
- Reset mid-stream: assert reset_i with 3 transactions in flight → the next cycle shows out_valid_o=0 and zero outputs, and none of those 3 results ever appears.
- Random regression: 10^5 random operands < Q with random mode and ready → match a golden model bit-exactly.
